alu_iter_exec: RTL and testbench

- Sequential execute unit on the consumer side of the alu_t control interface. It takes an ALU control code from the ALU control decoder together with two operands, and returns a result.
- Shifts run iteratively at SHIFT_STEP bits per cycle. All other operations complete in one cycle.
- Valid/ready handshakes on both sides let the pipeline stall around multi-cycle shifts.

---
 rtl/alu_iter_exec_if.sv | 66 ++++++
 rtl/alu_iter_exec.sv | 169 ++++++++++++++++
 tb/tb_alu_iter_exec.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_exec_if.sv
// ALU control code type shared by the decoder and the execute unit, plus the
// request/response bus used to talk to alu_iter_exec.

package alu_iter_pkg;

    // Encoding follows {funct7[5], funct3} so the decoder can pass it straight through.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_t;

endpackage

// Request side (in_valid/in_ready plus operands) and response side
// (out_valid/out_ready plus result flags) of the iterative execute unit.
interface alu_iter_exec_if #(
    parameter int XLEN = 32
);
    logic               in_valid;
    logic               in_ready;
    alu_iter_pkg::alu_t aluctr;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic               zero;
    logic               illegal;

    // Requester / result consumer (pipeline side).
    modport master (
        output in_valid,
        output aluctr,
        output op_a,
        output op_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero,
        input  illegal
    );

    // Execute unit side.
    modport slave (
        input  in_valid,
        input  aluctr,
        input  op_a,
        input  op_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output zero,
        output illegal
    );

endinterface

// File: rtl/alu_iter_exec.sv
// Iterative ALU execute unit. Single-cycle ops finish at the accept edge;
// shifts walk an accumulator SHIFT_STEP bits per cycle so only a small shifter
// is needed. Results are held in DONE until the consumer takes them.
// The XLEN parameter must match the XLEN of the connected interface instance.

module alu_iter_exec
    import alu_iter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_iter_exec_if.slave    bus
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] w_result_nxt;
    logic            r_illegal;
    logic            w_illegal_nxt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_acc_nxt;
    logic [SHW-1:0]  r_rem;
    logic [SHW-1:0]  w_rem_nxt;
    logic            r_left;
    logic            w_left_nxt;
    logic            r_fill;
    logic            w_fill_nxt;

    logic [SHW:0]    w_k;
    logic [SHW:0]    w_rem_left;
    logic [XLEN-1:0] w_fill_mask;
    logic [XLEN-1:0] w_shifted;

    logic [XLEN-1:0] w_alu;
    logic            w_alu_illegal;
    logic            w_is_shift;
    logic [SHW-1:0]  w_shamt;

    // One shift iteration: step by min(rem, SHIFT_STEP), filling with zeros or the captured sign.
    always_comb begin
        w_k = STEP_W;
        if ({1'b0, r_rem} < STEP_W) begin
            w_k = {1'b0, r_rem};
        end
        w_rem_left  = {1'b0, r_rem} - w_k;
        w_fill_mask = ~({XLEN{1'b1}} >> w_k);
        w_shifted   = '0;
        if (r_left) begin
            w_shifted = r_acc << w_k;
        end else begin
            w_shifted = (r_acc >> w_k) | (r_fill ? w_fill_mask : '0);
        end
    end

    // Decode the incoming request; shifts pass op_a through so shamt==0 completes immediately.
    always_comb begin
        w_alu         = '0;
        w_alu_illegal = 1'b0;
        w_is_shift    = 1'b0;
        w_shamt       = bus.op_b[SHW-1:0];
        case (bus.aluctr)
            ALU_ADD:  w_alu = bus.op_a + bus.op_b;
            ALU_SUB:  w_alu = bus.op_a - bus.op_b;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            ALU_XOR:  w_alu = bus.op_a ^ bus.op_b;
            ALU_OR:   w_alu = bus.op_a | bus.op_b;
            ALU_AND:  w_alu = bus.op_a & bus.op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                w_is_shift = 1'b1;
                w_alu      = bus.op_a;
            end
            default:  w_alu_illegal = 1'b1;
        endcase
    end

    // Next-state and next-datapath values; registers hold unless the state says otherwise.
    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_illegal_nxt = r_illegal;
        w_acc_nxt     = r_acc;
        w_rem_nxt     = r_rem;
        w_left_nxt    = r_left;
        w_fill_nxt    = r_fill;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_acc_nxt   = bus.op_a;
                        w_rem_nxt   = w_shamt;
                        w_left_nxt  = (bus.aluctr == ALU_SLL);
                        w_fill_nxt  = (bus.aluctr == ALU_SRA) && bus.op_a[XLEN-1];
                        w_state_nxt = SHIFT;
                    end else begin
                        w_result_nxt  = w_alu;
                        w_illegal_nxt = w_alu_illegal;
                        w_state_nxt   = DONE;
                    end
                end
            end
            SHIFT: begin
                w_acc_nxt = w_shifted;
                w_rem_nxt = w_rem_left[SHW-1:0];
                if (w_rem_left == '0) begin
                    w_result_nxt  = w_shifted;
                    w_illegal_nxt = 1'b0;
                    w_state_nxt   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any shift or pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result, flags and shift working registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_left    <= 1'b0;
            r_fill    <= 1'b0;
        end else begin
            r_result  <= w_result_nxt;
            r_illegal <= w_illegal_nxt;
            r_acc     <= w_acc_nxt;
            r_rem     <= w_rem_nxt;
            r_left    <= w_left_nxt;
            r_fill    <= w_fill_nxt;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: one instance with SHIFT_STEP=1 and one with
// SHIFT_STEP=4. Drivers push expected responses into per-instance queues and a
// negedge monitor compares whatever the units present against them.

module tb_alu_iter_exec;
    import alu_iter_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   monEn = 1'b0;
    bit   post[2];
    bit   seen[2];
    exp_t q1[$];
    exp_t q4[$];

    alu_iter_exec_if #(.XLEN(32)) bus1 ();
    alu_iter_exec_if #(.XLEN(32)) bus4 ();

    alu_iter_exec #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    alu_iter_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic driveBus(input int d, input logic v, input alu_t op, input logic [31:0] a, input logic [31:0] b);
        if (d == 0) begin
            bus1.in_valid = v; bus1.aluctr = op; bus1.op_a = a; bus1.op_b = b;
        end else begin
            bus4.in_valid = v; bus4.aluctr = op; bus4.op_a = a; bus4.op_b = b;
        end
    endtask

    // Issue one request, hold it until accepted, then scramble the operands.
    task automatic applyStimulus(input int d, input alu_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] er, input logic ei, input int el, input bit push);
        bit   ok = 1'b0;
        logic rdy;
        int   k = 0;
        exp_t item;
        driveBus(d, 1'b1, op, a, b);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = (d == 0) ? bus1.in_ready : bus4.in_ready;
            k = cyc;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        driveBus(d, 1'b0, op, ~a, ~b);
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            item.res = er; item.ill = ei; item.lat = el; item.acc = k;
            if (d == 0) q1.push_back(item);
            else q4.push_back(item);
        end
    endtask

    task automatic waitIdle();
        int left;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q4.size() == 0) break;
        end
        left = q1.size() + q4.size();
        checkOutput("drain_pending", 32'(left), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic monitorStep(input int d, input string tag, input logic ov, input logic ir, input logic orr,
                               input logic [31:0] res, input logic z, input logic ill);
        exp_t item;
        int   qs;
        if (post[d]) begin
            checkOutput({tag, "_post_hs_in_ready"}, 32'(ir), 32'd1);
            checkOutput({tag, "_post_hs_out_valid"}, 32'(ov), 32'd0);
            post[d] = 1'b0;
        end
        if (ov) begin
            checkOutput({tag, "_busy_in_ready"}, 32'(ir), 32'd0);
            qs = (d == 0) ? q1.size() : q4.size();
            if (qs == 0) begin
                checkOutput({tag, "_unexpected_out_valid"}, 32'd1, 32'd0);
            end else begin
                item = (d == 0) ? q1[0] : q4[0];
                checkOutput({tag, "_result"}, res, item.res);
                checkOutput({tag, "_zero"}, 32'(z), (item.res == 32'd0) ? 32'd1 : 32'd0);
                checkOutput({tag, "_illegal"}, 32'(ill), 32'(item.ill));
                if (!seen[d]) begin
                    checkOutput({tag, "_latency"}, 32'(cyc - item.acc), 32'(item.lat));
                    seen[d] = 1'b1;
                end
                if (orr) begin
                    if (d == 0) void'(q1.pop_front());
                    else void'(q4.pop_front());
                    seen[d] = 1'b0;
                    post[d] = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard monitor for both instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (monEn) begin
            monitorStep(0, "s1", bus1.out_valid, bus1.in_ready, bus1.out_ready, bus1.result, bus1.zero, bus1.illegal);
            monitorStep(1, "s4", bus4.out_valid, bus4.in_ready, bus4.out_ready, bus4.result, bus4.zero, bus4.illegal);
        end
    end

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        driveBus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
        driveBus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
        bus1.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("rst_result", bus1.result, 32'd0);
        checkOutput("rst_zero", 32'(bus1.zero), 32'd1);
        checkOutput("rst_illegal", 32'(bus1.illegal), 32'd0);
        checkOutput("rst4_in_ready", 32'(bus4.in_ready), 32'd1);
        checkOutput("rst4_out_valid", 32'(bus4.out_valid), 32'd0);
        monEn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-cycle ops, SHIFT_STEP=1");
        applyStimulus(0, ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 1'b1);
        applyStimulus(0, ALU_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1, 1'b1);
        applyStimulus(0, ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 1'b1);
        applyStimulus(0, ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 1'b1);
        applyStimulus(0, ALU_XOR,  32'h0F0F0F0F, 32'hFF00FF00, 32'hF00FF00F, 1'b0, 1, 1'b1);
        applyStimulus(0, ALU_OR,   32'h0F0F0F0F, 32'hFF00FF00, 32'hFF0FFF0F, 1'b0, 1, 1'b1);
        waitIdle();

        $display("[TB] shifts, SHIFT_STEP=1");
        applyStimulus(0, ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 5,  1'b1);
        applyStimulus(0, ALU_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1,  1'b1);
        applyStimulus(0, ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 32, 1'b1);
        applyStimulus(0, ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 32, 1'b1);
        waitIdle();

        $display("[TB] shifts, SHIFT_STEP=4");
        applyStimulus(1, ALU_SRL,  32'hF0000000, 32'h00000007, 32'h01E00000, 1'b0, 3, 1'b1);
        applyStimulus(1, ALU_SRA,  32'h80000000, 32'h00000009, 32'hFFC00000, 1'b0, 4, 1'b1);
        applyStimulus(1, ALU_SLL,  32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 2, 1'b1);
        applyStimulus(1, ALU_SLL,  32'h00000003, 32'h0000001F, 32'h80000000, 1'b0, 9, 1'b1);
        waitIdle();

        $display("[TB] backpressure");
        bus1.out_ready = 1'b0;
        applyStimulus(0, ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1, 1'b1);
        fork
            applyStimulus(0, ALU_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 bus1.out_ready = 1'b1;
            end
        join
        waitIdle();

        $display("[TB] reset during shift");
        applyStimulus(0, ALU_SRL, 32'hFFFF0000, 32'd20, 32'd0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready", 32'(bus1.in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("abort_result", bus1.result, 32'd0);
        checkOutput("abort_zero", 32'(bus1.zero), 32'd1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;

        $display("[TB] undefined code");
        applyStimulus(0, alu_t'(4'b1001), 32'h12345678, 32'h87654321, 32'h00000000, 1'b1, 1, 1'b1);
        applyStimulus(0, ALU_AND, 32'h0000FF00, 32'h00000FF0, 32'h00000F00, 1'b0, 1, 1'b1);
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
